cmd_tx_wrapper: RTL
===================

// Module: cmd_tx_wrapper
// PURPOSE
//  Transmit end of the command link: takes a 16-bit command word plus a send strobe and
//  serializes it onto one UART TX line as two 8N1 bytes, high byte first.
//  This is the exact byte order and framing the follower's UART_wrapper receiver reassembles into cmd/cmd_rdy.
//  Used in the remote/test-harness side of the design and in loopback benches against the receiver.
// PARAMETERS
//  BAUD_DIV   2604   clocks per bit (50 MHz / 19200 baud); legal range 4..4095, counter is 12 bits
// PORTS
//  clk        in   1   system clock; one clock, all logic on posedge clk
//  rst        in   1   reset is synchronous and active-high
//  cmd        in   16  command word; sampled only in the cycle snd_cmd is accepted
//  snd_cmd    in   1   single-cycle request to send cmd
//  TX         out  1   serial line, idles high
//  busy       out  1   high from the cycle after acceptance until cmd_sent rises
//  cmd_sent   out  1   sticky done flag; set when the low byte's stop bit completes, cleared by the next accepted snd_cmd
// BEHAVIOUR
//  Reset values: TX=1, busy=0, cmd_sent=0, sequencer IDLE, baud/bit counters 0, hold register 16'h0000.
//  Sequencer FSM (cmd_tx_wrapper):
//   IDLE: snd_cmd=1 -> capture cmd into hold reg, clear cmd_sent, pulse trmt with hold[15:8], go HIGH.
//   HIGH: wait tx_done -> pulse trmt with hold[7:0] in that same cycle, go LOW.
//   LOW:  wait tx_done -> set cmd_sent, go IDLE.
//  snd_cmd while busy (HIGH/LOW) is ignored entirely; cmd changes after acceptance have no effect.
//  snd_cmd in the same cycle cmd_sent would be set is not possible (FSM is still in LOW); accepted next cycle earliest.
//  uart_tx (sub-module) byte FSM:
//   IDLE: TX=1; trmt -> load {1'b1, data, 1'b0} into a 10-bit shift reg, clear baud and bit counters, go TXING.
//   TXING: TX = shift_reg[0]; baud_cnt counts 0..BAUD_DIV-1; at BAUD_DIV-1, shift right (fill 1), bit_cnt++.
//    After bit 9 (stop) completes its full BAUD_DIV clocks -> back to IDLE; tx_done pulses 1 clock in the first IDLE cycle.
//   Data bits go LSB-first. Every bit, including stop, lasts exactly BAUD_DIV clocks.
//   trmt while TXING is ignored.
//  Timing:
//   TX falls in the cycle after snd_cmd is accepted.
//   Exactly 1 idle-high clock between the high-byte stop bit and the low-byte start bit.
//   Total span: cmd_sent rises at cycle 20*BAUD_DIV+3 after the acceptance cycle (cycle 0).
//  Reset mid-operation: with rst high, next edge gives TX=1, IDLE, busy=0, cmd_sent=0.
//   The partial frame is abandoned, and no byte is resent after reset.
// STRUCTURE
//  Sub-module uart_tx (clk, rst, trmt, tx_data[7:0], TX, tx_done), parameterized by BAUD_DIV.
//  Shared package cmd_link_pkg:
//   typedef enum logic [1:0] {SEQ_IDLE, SEQ_HIGH, SEQ_LOW} seq_state_t
//   typedef enum logic {TX_IDLE, TX_TXING} tx_state_t
//   localparam DEFAULT_BAUD_DIV = 2604
//  The receiver side should import the same package constant so both ends agree on the baud rate.
// TESTING (bench BAUD_DIV=16)
//  1. snd_cmd @cycle0, cmd=16'hA5C3
//     -> TX low cycles 1-16; then bits of 0xA5 LSB-first (1,0,1,0,0,1,0,1), 16 clocks each; stop high
//     -> then 0xC3 frame starting cycle 162; cmd_sent=1 at cycle 323; busy=0 at 323.
//  2. Loopback into UART_wrapper with BAUD_DIV matched: send 16'h0003, then 16'hFFFF
//     -> receiver cmd equals each word and cmd_rdy asserts once per word.
//  3. snd_cmd pulsed again at cycle 50, cmd=16'h1234 while sending 16'hA5C3
//     -> waveform identical to scenario 1; only one cmd_sent rise.
//  4. After cmd_sent=1, snd_cmd with cmd=16'h0000 -> cmd_sent clears the next cycle
//     -> 0x00 frames are sent (start + eight 0s + stop).
//  5. rst asserted at cycle 100 mid-high-byte -> TX=1, busy=0, cmd_sent=0 at cycle 101
//     -> line stays high with no further transitions until a new snd_cmd.
//  6. cmd input toggled every cycle after acceptance -> transmitted bytes match the value captured at acceptance.

Source files
------------

// File: rtl/cmd_link_pkg.sv
// Shared definitions for both ends of the command link. The receiver imports the
// same baud constant so that transmitter and receiver always agree on bit timing.
package cmd_link_pkg;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_HIGH, SEQ_LOW} seq_state_t;
  typedef enum logic {TX_IDLE, TX_TXING} tx_state_t;

  // 50 MHz system clock / 19200 baud
  localparam int DEFAULT_BAUD_DIV = 2604;

  // An 8N1 frame in the order it leaves the shift register: start bit in bit 0,
  // data LSB-first, stop bit in bit 9.
  function automatic logic [9:0] frame_8n1(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/uart_tx.sv
// Single-byte 8N1 UART transmitter. A trmt pulse in IDLE starts one frame.
// Every bit, stop included, is held for exactly BAUD_DIV clocks. tx_done pulses
// for one clock in the first IDLE cycle after the stop bit.
module uart_tx
  import cmd_link_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  BIT_LAST  = 4'd9;

  tx_state_t   state_q, state_d;
  logic [9:0]  shift_q, shift_d;
  logic [11:0] baud_q,  baud_d;
  logic [3:0]  bit_q,   bit_d;
  logic        done_q,  done_d;

  // State, shift register, counters and done pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
    end
  end

  // Frame load, per-bit baud timing and shifting; trmt is ignored while TXING.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (trmt) begin
          shift_d = frame_8n1(tx_data);
          baud_d  = '0;
          bit_d   = '0;
          state_d = TX_TXING;
        end
      end
      TX_TXING: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b1, shift_q[9:1]};
          if (bit_q == BIT_LAST) begin
            // Stop bit has had its full BAUD_DIV clocks.
            bit_d   = '0;
            done_d  = 1'b1;
            state_d = TX_IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign TX      = (state_q == TX_TXING) ? shift_q[0] : 1'b1;
  assign tx_done = done_q;

endmodule

// File: rtl/cmd_tx_wrapper.sv
// Command-link transmitter: sends a 16-bit command as two 8N1 bytes, high byte
// first, and raises a sticky cmd_sent once the low byte's stop bit completes.
module cmd_tx_wrapper
  import cmd_link_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  output logic        busy,
  output logic        cmd_sent
);

  seq_state_t  state_q, state_d;
  logic [15:0] hold_q,  hold_d;
  logic        sent_q,  sent_d;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;

  // Sequencer state, captured command word and sticky done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      hold_q  <= '0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sent_q  <= sent_d;
    end
  end

  // Byte sequencing: high byte on acceptance, low byte on the first tx_done,
  // cmd_sent on the second. Requests while a word is in flight are dropped.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    sent_d  = sent_q;
    trmt    = 1'b0;
    tx_data = hold_q[7:0];
    case (state_q)
      SEQ_IDLE: begin
        if (snd_cmd) begin
          hold_d  = cmd;
          sent_d  = 1'b0;
          trmt    = 1'b1;
          // hold_q is loaded on this same edge, so take the high byte straight
          // from the value being captured.
          tx_data = cmd[15:8];
          state_d = SEQ_HIGH;
        end
      end
      SEQ_HIGH: begin
        if (tx_done) begin
          trmt    = 1'b1;
          tx_data = hold_q[7:0];
          state_d = SEQ_LOW;
        end
      end
      SEQ_LOW: begin
        if (tx_done) begin
          sent_d  = 1'b1;
          state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk    (clk),
    .rst    (rst),
    .trmt   (trmt),
    .tx_data(tx_data),
    .TX     (TX),
    .tx_done(tx_done)
  );

  assign busy     = (state_q != SEQ_IDLE);
  assign cmd_sent = sent_q;

endmodule
